// File: rtl/pcie_tx_arbiter_if.sv
// Requester beat bus (NUM_REQ sources) and the single PCIe TX stream.
// master: requesters + link side; slave: the arbiter.
interface pcie_tx_arbiter_if #(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned PCIE_DATA_WIDTH = 128
);
    logic [NUM_REQ*PCIE_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_last;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [PCIE_DATA_WIDTH-1:0]         pcie_tx_data;
    logic                               pcie_tx_valid;
    logic                               pcie_tx_last;
    logic                               pcie_tx_ready;

    modport master (
        output req_data, req_valid, req_last, pcie_tx_ready,
        input  req_ready, pcie_tx_data, pcie_tx_valid, pcie_tx_last
    );

    modport slave (
        input  req_data, req_valid, req_last, pcie_tx_ready,
        output req_ready, pcie_tx_data, pcie_tx_valid, pcie_tx_last
    );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter onto the PCIe TX link, one output register stage.
// Optional PCIE_TX_ARB_PRIO0_EN: requester 0 wins every arbitration it requests.
module pcie_tx_arbiter #(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned PCIE_DATA_WIDTH = 128,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                       pcie_clk,
    input  logic                       pcie_rst_n,
    pcie_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_timeout,
    input  logic                       err_clear
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                     state_q, state_d;
    logic [ID_W-1:0]            grant_q, grant_d;
    logic [ID_W-1:0]            rr_q, rr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       tx_valid_q, tx_valid_d;
    logic                       tx_last_q, tx_last_d;
    logic [PCIE_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                       err_q, err_d;
    logic                       err_set_c;
    logic                       accept_c;
    logic [NUM_REQ-1:0]         ready_c;
    logic [ID_W-1:0]            pick_c;
    logic                       found_c;
    logic [ID_W-1:0]            next_id_c;

    // First valid requester at or above the rr pointer, wrapping.
    always_comb begin : p_pick
        pick_c  = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found_c && bus.req_valid[ID_W'((32'(rr_q) + i) % NUM_REQ)]) begin
                found_c = 1'b1;
                pick_c  = ID_W'((32'(rr_q) + i) % NUM_REQ);
            end
        end
`ifdef PCIE_TX_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            found_c = 1'b1;
            pick_c  = '0;
        end
`endif
    end

    assign next_id_c = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

    always_comb begin : p_next
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        tx_data_d  = tx_data_q;
        err_set_c  = 1'b0;
        accept_c   = 1'b0;
        ready_c    = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found_c) begin
                    grant_d = pick_c;
                    state_d = XFER;
                end
            end
            XFER: begin
                ready_c[grant_q] = !tx_valid_q || bus.pcie_tx_ready;
                accept_c         = bus.req_valid[grant_q] && ready_c[grant_q];
                if (accept_c) begin
                    tx_data_d = bus.req_data[32'(grant_q)*PCIE_DATA_WIDTH +: PCIE_DATA_WIDTH];
                    tx_last_d = bus.req_last[grant_q];
                    cnt_d     = '0;
                    if (bus.req_last[grant_q]) begin
                        state_d = IDLE;
                        rr_d    = next_id_c;
`ifdef PCIE_TX_ARB_PRIO0_EN
                        if (grant_q == '0) rr_d = rr_q;
`endif
                    end
                end else if (!bus.req_valid[grant_q]) begin
                    // Abandon a packet whose source has gone silent mid-stream.
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_set_c = 1'b1;
                        state_d   = IDLE;
                        rr_d      = next_id_c;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c)                tx_valid_d = 1'b1;
        else if (bus.pcie_tx_ready)  tx_valid_d = 1'b0;

        err_d = err_set_c ? 1'b1 : (err_clear ? 1'b0 : err_q);
    end

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin : p_regs
        if (!pcie_rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready     = ready_c;
    assign bus.pcie_tx_data  = tx_data_q;
    assign bus.pcie_tx_valid = tx_valid_q;
    assign bus.pcie_tx_last  = tx_last_q;
    assign grant_id          = grant_q;
    assign busy              = (state_q == XFER);
    assign err_timeout       = err_q;
endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_pcie_tx_arbiter;
    localparam int unsigned N   = 3;
    localparam int unsigned W   = 128;
    localparam int          T   = 64;
    localparam int unsigned IDW = $clog2(N);
`ifdef PCIE_TX_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] d;
        bit           l;
        int           gap;
    } beat_t;

    typedef struct {
        logic [W-1:0] d;
        bit           l;
    } obs_t;

    logic           pcie_clk   = 1'b0;
    logic           pcie_rst_n = 1'b0;
    logic           err_clear  = 1'b0;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           err_timeout;

    pcie_tx_arbiter_if #(.NUM_REQ(N), .PCIE_DATA_WIDTH(W)) bus ();

    pcie_tx_arbiter #(.NUM_REQ(N), .PCIE_DATA_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .pcie_clk   (pcie_clk),
        .pcie_rst_n (pcie_rst_n),
        .bus        (bus),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_clear  (err_clear)
    );

    always #5 pcie_clk = ~pcie_clk;

    int total = 0;
    int bad   = 0;

    // requester-side beat queues and driver state
    beat_t q [N][$];
    int    gcnt [N];
    bit    gl   [N];
    bit    flush     = 1'b0;
    bit    rdy_force = 1'b1;
    bit    rdy_val   = 1'b1;
    int    rdy_pct   = 70;
    obs_t  olog [$];

    // model: owner of the link (-1 = arbitrating), rr pointer, silent-cycle run
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_idle  = 0;
    int           m_grant = 0;
    bit           m_tv    = 1'b0;
    bit           m_tl    = 1'b0;
    logic [W-1:0] m_td    = '0;
    bit           m_err   = 1'b0;
    bit [N-1:0]   m_acc   = '0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_step();
        bit set_err;
        int g;
        int pick;
        m_acc   = '0;
        set_err = 1'b0;
        if (!pcie_rst_n) begin
            m_owner = -1; m_ptr = 0; m_idle = 0; m_grant = 0;
            m_tv = 1'b0; m_tl = 1'b0; m_td = '0; m_err = 1'b0;
            return;
        end
        if (m_owner < 0) begin
            pick = -1;
            if (PRIO0 && bus.req_valid[0]) pick = 0;
            for (int k = 0; k < N; k++)
                if (pick < 0 && bus.req_valid[IDW'((m_ptr + k) % N)]) pick = (m_ptr + k) % N;
            if (pick >= 0) begin
                m_owner = pick;
                m_grant = pick;
                m_idle  = 0;
            end
        end else begin
            g = m_owner;
            if (bus.req_valid[g] && (!m_tv || bus.pcie_tx_ready)) begin
                m_acc[g] = 1'b1;
                m_idle   = 0;
                m_td     = bus.req_data[g*W +: W];
                m_tl     = bus.req_last[g];
                if (m_tl) begin
                    m_owner = -1;
                    if (!PRIO0 || g != 0) m_ptr = (g + 1) % N;
                end
            end else if (!bus.req_valid[g]) begin
                m_idle++;
                if (m_idle == T) begin
                    set_err = 1'b1;
                    m_owner = -1;
                    m_ptr   = (g + 1) % N;
                    m_idle  = 0;
                end
            end
        end
        if (m_acc != '0)             m_tv = 1'b1;
        else if (bus.pcie_tx_ready)  m_tv = 1'b0;
        if (set_err)        m_err = 1'b1;
        else if (err_clear) m_err = 1'b0;
    endfunction

    task automatic drive();
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                q[i].delete();
                gl[i] = 1'b0;
            end
            bus.req_valid = '0;
            bus.req_last  = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_acc[i]) begin
                    void'(q[i].pop_front());
                    gl[i] = 1'b0;
                end
                if (!(bus.req_valid[i] && !m_acc[i])) begin
                    bus.req_valid[i] = 1'b0;
                    if (q[i].size() != 0) begin
                        if (!gl[i]) begin
                            gcnt[i] = q[i][0].gap;
                            gl[i]   = 1'b1;
                        end
                        if (gcnt[i] > 0) gcnt[i]--;
                        else begin
                            bus.req_valid[i]        = 1'b1;
                            bus.req_data[i*W +: W]  = q[i][0].d;
                            bus.req_last[i]         = q[i][0].l;
                        end
                    end
                end
            end
        end
        if (rdy_force) bus.pcie_tx_ready = rdy_val;
        else           bus.pcie_tx_ready = ($urandom_range(99) < 32'(rdy_pct));
    endtask

    // stimulus + model advance on each active edge
    initial begin
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.req_data      = '0;
        bus.pcie_tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            gcnt[i] = 0;
            gl[i]   = 1'b0;
        end
        forever begin
            @(posedge pcie_clk);
            model_step();
            #1;
            drive();
        end
    end

    // compare process: every cycle, on the falling edge
    initial begin
        logic [N-1:0] er;
        forever begin
            @(negedge pcie_clk);
            er = '0;
            if (pcie_rst_n && m_owner >= 0 && (!m_tv || bus.pcie_tx_ready)) er[m_owner] = 1'b1;
            chk("req_ready", W'(bus.req_ready), W'(er));
            chk("tx_valid", W'(bus.pcie_tx_valid), W'(m_tv));
            if (m_tv) begin
                chk("tx_data", bus.pcie_tx_data, m_td);
                chk("tx_last", W'(bus.pcie_tx_last), W'(m_tl));
            end
            chk("grant_id", W'(grant_id), W'(m_grant));
            chk("busy", W'(busy), W'(m_owner >= 0));
            chk("err_timeout", W'(err_timeout), W'(m_err));
            if (pcie_rst_n && bus.pcie_tx_valid && bus.pcie_tx_ready)
                olog.push_back('{d: bus.pcie_tx_data, l: bus.pcie_tx_last});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pcie_clk);
        #2;
    endtask

    task automatic push(input int i, input int n, input logic [W-1:0] base, input int gap0, input int gapm);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d   = base + W'(k);
            b.l   = (k == n - 1);
            b.gap = (k == 0) ? gap0 : gapm;
            q[i].push_back(b);
        end
    endtask

    task automatic push_rand(input int i);
        beat_t b;
        int n = int'($urandom_range(5, 1));
        for (int k = 0; k < n; k++) begin
            b.d   = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.l   = (k == n - 1);
            b.gap = ($urandom_range(39) == 0) ? T + 5 :
                    (($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0);
            q[i].push_back(b);
        end
    endtask

    function automatic bit all_done();
        bit d = !busy && !bus.pcie_tx_valid && (bus.req_valid == '0);
        for (int i = 0; i < N; i++) if (q[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!all_done() && n < budget) begin
            cyc(1);
            n++;
        end
        chk(nm, W'(all_done()), W'(1));
    endtask

    task automatic do_reset();
        pcie_rst_n = 1'b0;
        flush      = 1'b1;
        cyc(2);
        flush      = 1'b0;
        pcie_rst_n = 1'b1;
        olog.delete();
    endtask

    initial begin
        int n;
        int exp_ord [6];
        logic [W-1:0] d;
        cyc(3);
        pcie_rst_n = 1'b1;

        // idle link stays quiet
        cyc(20);
        chk("idle_busy", W'(busy), W'(0));
        chk("idle_tx_valid", W'(bus.pcie_tx_valid), W'(0));
        chk("idle_req_ready", W'(bus.req_ready), W'(0));

        // requester 1, four beats
        push(1, 4, W'('h11), 0, 0);
        cyc(1);
        chk("r1_arb_grant", W'(grant_id), W'(0));
        chk("r1_arb_busy", W'(busy), W'(0));
        cyc(1);
        chk("r1_grant", W'(grant_id), W'(1));
        chk("r1_busy", W'(busy), W'(1));
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("r1_beat_valid", W'(bus.pcie_tx_valid), W'(1));
            chk("r1_beat_data", bus.pcie_tx_data, W'('h11 + k));
            chk("r1_beat_last", W'(bus.pcie_tx_last), W'(k == 3));
        end
        chk("r1_back_idle", W'(busy), W'(0));
        cyc(1);
        chk("r1_drained", W'(bus.pcie_tx_valid), W'(0));
        wait_done("r1_done", 50);

        // three requesters, two 2-beat packets each
        do_reset();
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 2; p++) push(i, 2, W'((i << 8) | (p << 4)), 0, 0);
        wait_done("rr_done", 200);
        if (PRIO0) exp_ord = '{0, 0, 1, 2, 1, 2};
        else       exp_ord = '{0, 1, 2, 0, 1, 2};
        chk("rr_beats", W'(olog.size()), W'(12));
        if (olog.size() == 12) begin
            for (int p = 0; p < 6; p++) begin
                d = olog[2*p].d;
                chk("rr_order", W'(d[11:8]), W'(exp_ord[p]));
                chk("rr_pair", olog[2*p+1].d, olog[2*p].d + W'(1));
                chk("rr_last", W'({olog[2*p].l, olog[2*p+1].l}), W'(1));
            end
        end

        // output stall on requester 0
        do_reset();
        rdy_val = 1'b0;
        push(0, 3, W'('h41), 0, 0);
        n = 0;
        while (!bus.pcie_tx_valid && n < 20) begin cyc(1); n++; end
        chk("stall_first", bus.pcie_tx_data, W'('h41));
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("stall_hold", bus.pcie_tx_data, W'('h41));
            chk("stall_ready", W'(bus.req_ready[0]), W'(0));
        end
        rdy_val = 1'b1;
        wait_done("stall_done", 50);
        chk("stall_beats", W'(olog.size()), W'(3));
        for (int k = 0; k < 3 && k < olog.size(); k++)
            chk("stall_data", olog[k].d, W'('h41 + k));

        // mid-packet timeout on requester 2
        do_reset();
        push(2, 2, W'('h51), 0, T + 6);
        push(0, 1, W'('h61), 30, 0);
        n = 0;
        while (!bus.pcie_tx_valid && n < 20) begin cyc(1); n++; end
        chk("tmo_first", bus.pcie_tx_data, W'('h51));
        n = 0;
        while (!err_timeout && n < 200) begin cyc(1); n++; end
        chk("tmo_cycles", W'(n), W'(64));
        chk("tmo_idle", W'(busy), W'(0));
        cyc(1);
        chk("tmo_next_grant", W'(grant_id), W'(0));
        chk("tmo_next_busy", W'(busy), W'(1));
        cyc(3);
        chk("tmo_sticky", W'(err_timeout), W'(1));
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        chk("tmo_cleared", W'(err_timeout), W'(0));
        wait_done("tmo_done", 200);

        // reset in the middle of a packet
        do_reset();
        push(0, 1, W'('h71), 0, 0);
        wait_done("rst_pre", 50);
        push(1, 4, W'('h81), 0, 0);
        n = 0;
        while (!(bus.pcie_tx_valid && bus.pcie_tx_data == W'('h82)) && n < 20) begin cyc(1); n++; end
        chk("rst_at_beat2", bus.pcie_tx_data, W'('h82));
        pcie_rst_n = 1'b0;
        flush      = 1'b1;
        #1;
        chk("rst_req_ready", W'(bus.req_ready), W'(0));
        chk("rst_tx_valid", W'(bus.pcie_tx_valid), W'(0));
        chk("rst_tx_last", W'(bus.pcie_tx_last), W'(0));
        chk("rst_tx_data", bus.pcie_tx_data, W'(0));
        chk("rst_grant", W'(grant_id), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        cyc(2);
        flush      = 1'b0;
        pcie_rst_n = 1'b1;
        olog.delete();
        push(0, 1, W'('h91), 0, 0);
        push(1, 1, W'('hA1), 0, 0);
        wait_done("rst_post", 50);
        if (olog.size() > 0) chk("rst_rr_ptr", olog[0].d, W'('h91));
        else                 chk("rst_rr_ptr", W'(0), W'('h91));

        // randomized traffic
        do_reset();
        rdy_force = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            cyc(1);
            for (int i = 0; i < N; i++)
                if (q[i].size() < 2 && $urandom_range(9) == 0) push_rand(i);
            err_clear = ($urandom_range(19) == 0);
        end
        err_clear = 1'b0;
        rdy_force = 1'b1;
        rdy_val   = 1'b1;
        wait_done("rand_done", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pcie_tx_arbiter.md
Name: pcie_tx_arbiter

Overview:
Shares the single 128-bit PCIe TX link between NUM_REQ packet sources, such as the NPU TX FIFO drain, DMA completions and status/interrupt messages. Arbitration is round-robin at packet granularity: once granted, a requester owns the link until its last beat is accepted. One registered output stage sits in front of the PCIe TX interface. The whole block runs in the pcie_clk domain.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
PCIE_DATA_WIDTH, 128, beat width in bits
TIMEOUT_CYCLES, 64, consecutive idle cycles of the granted requester mid-packet before abort (>=2)

Ports:
pcie_clk  in  1  clock
pcie_rst_n  in  1  reset
req_data  in  NUM_REQ*PCIE_DATA_WIDTH  requester i beat at slice [i*W +: W]
req_valid  in  NUM_REQ  beat valid per requester
req_last  in  NUM_REQ  final beat of packet per requester
req_ready  out  NUM_REQ  beat accepted from requester i when req_valid[i]&&req_ready[i]
pcie_tx_data  out  PCIE_DATA_WIDTH  registered output beat
pcie_tx_valid  out  1  output beat valid
pcie_tx_last  out  1  output beat is end of packet
pcie_tx_ready  in  1  link accepts beat
grant_id  out  $clog2(NUM_REQ)  current/last granted requester
busy  out  1  high in XFER state
err_timeout  out  1  sticky mid-packet timeout flag
err_clear  in  1  clears err_timeout

Behaviour:
- Clock and reset: clock pcie_clk; reset pcie_rst_n, asynchronous, active-low.
- Reset values: req_ready=0, pcie_tx_valid=0, pcie_tx_last=0, pcie_tx_data=0, grant_id=0, busy=0, err_timeout=0, rr pointer=0, state=IDLE, timeout counter=0.
- FSM states: IDLE and XFER.
- IDLE:
  - If any req_valid is set, select the first set bit searching upward from rr pointer, with wrap-around.
  - Register grant_id and move to XFER on the next cycle.
  - The arbitration decision costs 1 cycle; req_ready is 0 in IDLE.
- XFER:
  - req_ready[grant_id] = (!pcie_tx_valid || pcie_tx_ready). All other req_ready bits are 0.
  - On accept, the output register loads req_data, and pcie_tx_last takes req_last. pcie_tx_valid=1.
  - Latency is 1 cycle from accept to pcie_tx_valid.
- Output drain: if pcie_tx_ready=1 and no new beat loads that cycle, clear pcie_tx_valid. Simultaneous drain and load gives back-to-back beats with no bubble.
- Stall: while pcie_tx_valid=1 and pcie_tx_ready=0, the output register holds its value and req_ready=0.
- Packet end: when an accepted beat has req_last=1, go to IDLE and set rr pointer = (grant_id+1) mod NUM_REQ. The last beat may still sit in the output register while the next arbitration runs.
- Timeout counter:
  - Increments in XFER on each cycle with req_valid[grant_id]=0, and resets on any accept.
  - When it reaches TIMEOUT_CYCLES-1 with valid still low: set err_timeout, go to IDLE, rr pointer = grant_id+1.
  - No synthetic last beat is emitted; downstream treats the truncated packet as an error.
- err_timeout: err_clear clears it. If a set and a clear occur in the same cycle, set wins.
- busy = (state==XFER).
- Single-beat packet (req_last on first beat): XFER lasts 1 accept cycle, then IDLE.
- Reset mid-packet: all state returns to reset values immediately, and any in-flight output beat is dropped.
- req_valid deasserted by a non-granted requester has no effect. Requesters must hold data stable while valid && !ready.

Optional Feature:
PCIE_TX_ARB_PRIO0_EN:
- When defined, requester 0 has strict priority in IDLE: if req_valid[0]=1 it wins regardless of rr pointer. The rr pointer is not advanced after a requester-0 packet. Packets in progress are never pre-empted.
- When not defined, pure round-robin applies to all requesters.

Test Plan:
- Reset, then req_valid=3'b000 -> pcie_tx_valid=0, busy=0, req_ready=0 indefinitely.
- Requester 1 sends a 4-beat packet (data 0x11..0x14, last on beat 4), pcie_tx_ready=1 -> grant_id=1 one cycle after valid; 4 consecutive output beats with pcie_tx_last only on 0x14; return to IDLE.
- All 3 requesters continuously send 2-beat packets -> grant order 0,1,2,0,1,2 with no interleaving of beats within a packet. With PCIE_TX_ARB_PRIO0_EN the order is 0,0,0...
- Requester 0 sends 3 beats; pcie_tx_ready held 0 for 5 cycles after the first beat -> pcie_tx_data stays at beat 1, req_ready[0]=0; the remaining beats follow once ready returns.
- Requester 2 sends 1 beat without last, then req_valid[2]=0 for 64 cycles -> err_timeout=1 at cycle 64, FSM in IDLE, requester 0 is granted next. err_clear pulse -> err_timeout=0.
- pcie_rst_n asserted mid-packet on beat 2 of 4 -> all outputs at reset values in the same cycle; after release, a new arbitration starts with rr pointer=0.
